// File: rtl/coil_hbridge_driver.sv
// ---------------------------------------------------------------------------
// coil_hbridge_driver
//
// Drives the four gates of a coil H-bridge from a decoded 4-bit amplitude and
// a current-direction flag. Provides 15-step PWM on the active high-side gate,
// a fixed all-off dead time on every polarity change, and a watchdog that
// latches a fault when a drive phase lasts too long.
//
// Ports:
//   CLK_IN            system clock
//   rst               synchronous, active-high reset
//   enable            bridge enable
//   positive_current  requested phase: 1 = A-high/B-low, 0 = B-high/A-low
//   amplitude[3:0]    duty request, 0..15 (duty = amplitude/15)
//   HA, LA            leg A high-side / low-side gate
//   HB, LB            leg B high-side / low-side gate
//   fault             sticky watchdog fault, cleared by dropping enable
//   state_dbg[2:0]    current state encoding
//
// Every gate is a register loaded from a decode of the next state. Each drive
// state asserts exactly one low-side gate and can only ever assert the
// high-side gate of the opposite leg, so no state can produce shoot-through.
// ---------------------------------------------------------------------------
module coil_hbridge_driver #(
    parameter int PRESCALE  = 4,       // CLK_IN cycles per PWM tick
    parameter int DEAD_TIME = 8,       // all-off cycles between drive phases
    parameter int WATCHDOG  = 100000   // max cycles in one drive phase
) (
    input  logic       CLK_IN,
    input  logic       rst,
    input  logic       enable,
    input  logic       positive_current,
    input  logic [3:0] amplitude,
    output logic       HA,
    output logic       LA,
    output logic       HB,
    output logic       LB,
    output logic       fault,
    output logic [2:0] state_dbg
);

    localparam int WD_W   = $clog2(WATCHDOG);
    localparam int DEAD_W = $clog2(DEAD_TIME + 1);
    localparam int PS_W   = $clog2(PRESCALE + 1);

    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WATCHDOG - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TIME - 1);
    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [3:0]        PWM_LAST  = 4'd14;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        DEAD    = 3'd1,
        DRV_POS = 3'd2,
        DRV_NEG = 3'd3,
        FAULT   = 3'd4
    } state_t;

    state_t            state,    state_nxt;
    logic              tgt_pol,  tgt_nxt;
    logic [DEAD_W-1:0] dead_cnt, dead_nxt;
    logic [WD_W-1:0]   wd_cnt,   wd_nxt;
    logic [PS_W-1:0]   ps_cnt,   ps_nxt;
    logic [3:0]        pwm_cnt,  pwm_nxt;
    logic [3:0]        amp_q,    amp_nxt;
    logic              pwm_on_nxt;
    logic [3:0]        gates_nxt;   // {HA, LA, HB, LB}

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge CLK_IN) begin
        if (rst) begin
            state          <= OFF;
            tgt_pol        <= 1'b1;
            dead_cnt       <= '0;
            wd_cnt         <= '0;
            ps_cnt         <= '0;
            pwm_cnt        <= '0;
            amp_q          <= '0;
            {HA, LA, HB, LB} <= 4'b0000;
            fault          <= 1'b0;
        end else begin
            state          <= state_nxt;
            tgt_pol        <= tgt_nxt;
            dead_cnt       <= dead_nxt;
            wd_cnt         <= wd_nxt;
            ps_cnt         <= ps_nxt;
            pwm_cnt        <= pwm_nxt;
            amp_q          <= amp_nxt;
            {HA, LA, HB, LB} <= gates_nxt;
            fault          <= (state_nxt == FAULT);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_pol;
        dead_nxt  = dead_cnt;
        wd_nxt    = wd_cnt;
        ps_nxt    = ps_cnt;
        pwm_nxt   = pwm_cnt;
        amp_nxt   = amp_q;

        case (state)
            OFF: begin
                dead_nxt = '0;
                if (enable) begin
                    state_nxt = DEAD;
                    tgt_nxt   = positive_current;
                end
            end

            DEAD: begin
                if (!enable) begin
                    state_nxt = OFF;
                end else if (dead_cnt == DEAD_LAST) begin
                    // Start the new phase on a clean PWM period.
                    amp_nxt   = amplitude;
                    pwm_nxt   = '0;
                    ps_nxt    = '0;
                    wd_nxt    = '0;
                    dead_nxt  = '0;
                    state_nxt = tgt_pol ? DRV_POS : DRV_NEG;
                end else begin
                    dead_nxt = dead_cnt + 1'b1;
                end
            end

            DRV_POS, DRV_NEG: begin
                // PWM runs only while driving; amplitude is resampled at the
                // period wrap so a mid-period change never truncates a pulse.
                if (ps_cnt == PS_LAST) begin
                    ps_nxt = '0;
                    if (pwm_cnt == PWM_LAST) begin
                        pwm_nxt = '0;
                        amp_nxt = amplitude;
                    end else begin
                        pwm_nxt = pwm_cnt + 1'b1;
                    end
                end else begin
                    ps_nxt = ps_cnt + 1'b1;
                end

                if (!enable) begin
                    state_nxt = OFF;
                end else if (wd_cnt == WD_LAST) begin
                    state_nxt = FAULT;
                end else if (positive_current != (state == DRV_POS)) begin
                    state_nxt = DEAD;
                    tgt_nxt   = positive_current;
                    dead_nxt  = '0;
                end else begin
                    wd_nxt = wd_cnt + 1'b1;
                end
            end

            FAULT: begin
                if (!enable) begin
                    state_nxt = OFF;
                end
            end

            default: state_nxt = OFF;
        endcase
    end

    // ------------------------------------------------------------------
    // Gate decode from the next state, so the gate registers change on the
    // same edge as the state register.
    // ------------------------------------------------------------------
    always_comb begin
        pwm_on_nxt = (pwm_nxt < amp_nxt);
        case (state_nxt)
            DRV_POS: gates_nxt = {pwm_on_nxt, 1'b0, 1'b0, 1'b1};
            DRV_NEG: gates_nxt = {1'b0, 1'b1, pwm_on_nxt, 1'b0};
            default: gates_nxt = 4'b0000;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_coil_hbridge_driver.sv
// ---------------------------------------------------------------------------
// tb_coil_hbridge_driver
//
// Two instances share clock and reset: the main one (long watchdog) covers
// dead time, PWM duty, amplitude latching, phase changes, enable and reset;
// the second one (WATCHDOG = 50) covers fault entry, hold and clearing.
// Expected outputs are queued when the stimulus for a cycle is applied and
// compared once the clock edge has produced the DUT response.
// ---------------------------------------------------------------------------
module tb_coil_hbridge_driver;

    localparam int PRESCALE  = 4;
    localparam int DEAD_TIME = 8;
    localparam int WATCHDOG  = 1000;
    localparam int WD_SHORT  = 50;

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_DEAD  = 3'd1;
    localparam logic [2:0] S_POS   = 3'd2;
    localparam logic [2:0] S_NEG   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;
    localparam logic [3:0] G_OFF   = 4'b0000;

    logic       CLK_IN = 1'b0;
    logic       rst    = 1'b1;

    logic       enable           = 1'b0;
    logic       positive_current = 1'b1;
    logic [3:0] amplitude        = 4'd0;
    logic       HA, LA, HB, LB, fault;
    logic [2:0] state_dbg;

    logic       wd_enable           = 1'b0;
    logic       wd_positive_current = 1'b1;
    logic [3:0] wd_amplitude        = 4'd0;
    logic       wd_ha, wd_la, wd_hb, wd_lb, wd_fault;
    logic [2:0] wd_state_dbg;

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic inv_on       = 1'b0;

    typedef struct {
        string      tag;
        logic       wd;
        logic [7:0] exp;   // {HA, LA, HB, LB, fault, state}
    } exp_t;

    exp_t sb_q[$];

    coil_hbridge_driver #(
        .PRESCALE (PRESCALE),
        .DEAD_TIME(DEAD_TIME),
        .WATCHDOG (WATCHDOG)
    ) dut (
        .CLK_IN          (CLK_IN),
        .rst             (rst),
        .enable          (enable),
        .positive_current(positive_current),
        .amplitude       (amplitude),
        .HA              (HA),
        .LA              (LA),
        .HB              (HB),
        .LB              (LB),
        .fault           (fault),
        .state_dbg       (state_dbg)
    );

    coil_hbridge_driver #(
        .PRESCALE (PRESCALE),
        .DEAD_TIME(DEAD_TIME),
        .WATCHDOG (WD_SHORT)
    ) dut_wd (
        .CLK_IN          (CLK_IN),
        .rst             (rst),
        .enable          (wd_enable),
        .positive_current(wd_positive_current),
        .amplitude       (wd_amplitude),
        .HA              (wd_ha),
        .LA              (wd_la),
        .HB              (wd_hb),
        .LB              (wd_lb),
        .fault           (wd_fault),
        .state_dbg       (wd_state_dbg)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [3:0] pos_gates(input logic on);
        return {on, 1'b0, 1'b0, 1'b1};
    endfunction

    function automatic logic [3:0] neg_gates(input logic on);
        return {1'b0, 1'b1, on, 1'b0};
    endfunction

    function automatic logic inv_bad(input logic ha, input logic la, input logic hb, input logic lb);
        return (ha & la) | (hb & lb) | (ha & hb) | (ha & lb & (hb | la))
             | (ha & ~lb) | (hb & ~la);
    endfunction

    // Queue the expected response to the inputs currently applied, let one
    // edge happen, then compare against the selected instance.
    task automatic tick(input string tag, input logic wd, input logic [3:0] g,
                        input logic f, input logic [2:0] s);
        exp_t e;
        exp_t got_e;
        e.tag = tag;
        e.wd  = wd;
        e.exp = {g, f, s};
        sb_q.push_back(e);
        @(posedge CLK_IN);
        #1;
        got_e = sb_q.pop_front();
        if (got_e.wd)
            check(got_e.tag, {24'd0, wd_ha, wd_la, wd_hb, wd_lb, wd_fault, wd_state_dbg}, {24'd0, got_e.exp});
        else
            check(got_e.tag, {24'd0, HA, LA, HB, LB, fault, state_dbg}, {24'd0, got_e.exp});
    endtask

    // Gate-safety invariants on both instances, every cycle after reset.
    always @(negedge CLK_IN) begin
        if (inv_on) begin
            check("invariant", {31'd0, inv_bad(HA, LA, HB, LB)}, 32'd0);
            check("invariant_wd", {31'd0, inv_bad(wd_ha, wd_la, wd_hb, wd_lb)}, 32'd0);
        end
    end

    initial begin
        int   ha_cnt;
        int   amp_exp;
        logic on;

        // Reset
        repeat (3) tick("reset", 1'b0, G_OFF, 1'b0, S_OFF);
        inv_on = 1'b1;

        // Enable into positive phase with zero amplitude
        rst              = 1'b0;
        enable           = 1'b1;
        positive_current = 1'b1;
        amplitude        = 4'd0;
        for (int i = 0; i < DEAD_TIME; i++) tick("dead_start", 1'b0, G_OFF, 1'b0, S_DEAD);

        // Four PWM periods of 60 cycles: amplitude 0, 15, 5, 10. Each request
        // is made mid-period and only appears at the following period.
        ha_cnt = 0;
        for (int k = 0; k < 240; k++) begin
            if (k == 1)   amplitude = 4'd15;
            if (k == 70)  amplitude = 4'd5;
            if (k == 125) amplitude = 4'd10;
            case (k / 60)
                0:       amp_exp = 0;
                1:       amp_exp = 15;
                2:       amp_exp = 5;
                default: amp_exp = 10;
            endcase
            on = (((k % 60) / PRESCALE) < amp_exp);
            tick("drive_pos", 1'b0, pos_gates(on), 1'b0, S_POS);
            if ((k / 60) == 2 && HA) ha_cnt++;
        end
        check("duty_5_of_15", ha_cnt, 32'd20);

        // Polarity change: full dead time, then negative drive with pulses
        positive_current = 1'b0;
        for (int i = 0; i < DEAD_TIME; i++) tick("dead_pos_to_neg", 1'b0, G_OFF, 1'b0, S_DEAD);
        for (int j = 0; j < 64; j++) begin
            on = (((j % 60) / PRESCALE) < 10);
            tick("drive_neg", 1'b0, neg_gates(on), 1'b0, S_NEG);
        end

        // Reset while HB is high
        rst = 1'b1;
        tick("rst_mid_neg", 1'b0, G_OFF, 1'b0, S_OFF);
        check("rst_amp_q", {28'd0, dut.amp_q}, 32'd0);
        rst = 1'b0;

        // Drop enable during dead time, then re-enable for a full dead time
        for (int i = 0; i < 3; i++) tick("dead_after_rst", 1'b0, G_OFF, 1'b0, S_DEAD);
        enable = 1'b0;
        tick("off_from_dead", 1'b0, G_OFF, 1'b0, S_OFF);
        enable = 1'b1;
        for (int i = 0; i < DEAD_TIME; i++) tick("dead_restart", 1'b0, G_OFF, 1'b0, S_DEAD);
        for (int j = 0; j < 4; j++) tick("drive_neg2", 1'b0, neg_gates(1'b1), 1'b0, S_NEG);

        // Enable drop together with a phase change goes to OFF
        enable           = 1'b0;
        positive_current = 1'b1;
        tick("off_from_neg", 1'b0, G_OFF, 1'b0, S_OFF);
        tick("off_hold", 1'b0, G_OFF, 1'b0, S_OFF);

        // Watchdog instance: fault after WD_SHORT drive cycles
        wd_enable           = 1'b1;
        wd_positive_current = 1'b1;
        wd_amplitude        = 4'd15;
        for (int i = 0; i < DEAD_TIME; i++) tick("wd_dead", 1'b1, G_OFF, 1'b0, S_DEAD);
        for (int k = 0; k < WD_SHORT; k++) tick("wd_drive", 1'b1, pos_gates(1'b1), 1'b0, S_POS);
        wd_positive_current = 1'b0;   // same cycle as expiry: watchdog wins
        tick("wd_fault", 1'b1, G_OFF, 1'b1, S_FAULT);
        for (int i = 0; i < 4; i++) begin
            wd_positive_current = ~wd_positive_current;
            tick("fault_hold", 1'b1, G_OFF, 1'b1, S_FAULT);
        end
        wd_enable = 1'b0;
        tick("fault_clear", 1'b1, G_OFF, 1'b0, S_OFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
